// File: rtl/ecc_pkg.sv
// Shared ECC datapath constants, state encoding and limb types.
// Used by the modular subtractor and its benches.
package ecc_pkg;

  localparam int WIDTH = 256;
  localparam int LIMB  = 64;
  localparam int NLIMB = WIDTH / LIMB;
  localparam int CNT_W = (NLIMB > 1) ? $clog2(NLIMB) : 1;

  localparam logic [WIDTH-1:0] P256K1 =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  typedef enum logic [1:0] {
    IDLE,
    SUB,
    CORR,
    OUT
  } state_t;

  typedef logic [NLIMB-1:0][LIMB-1:0] limbs_t;

endpackage

// File: rtl/limb_addsub.sv
// One-limb combinational adder/subtractor with carry/borrow chaining.
// sub=1: a - b - cin, cout is borrow; sub=0: a + b + cin.
module limb_addsub
  import ecc_pkg::*;
(
  input  logic            sub,
  input  logic [LIMB-1:0] a,
  input  logic [LIMB-1:0] b,
  input  logic            cin,
  output logic [LIMB-1:0] sum,
  output logic            cout
);

  logic [LIMB:0] wide;
  logic [LIMB:0] cin_w;

  assign cin_w = {{LIMB{1'b0}}, cin};

  // Top bit of the widened result is the carry or the wrapped borrow
  always_comb begin
    if (sub) wide = {1'b0, a} - {1'b0, b} - cin_w;
    else     wide = {1'b0, a} + {1'b0, b} + cin_w;
  end

  assign sum  = wide[LIMB-1:0];
  assign cout = wide[LIMB];

endmodule

// File: rtl/sub_mod_seq.sv
// Limb-serial modular subtractor: (opA - opB) mod opM.
// Subtract pass, then an optional +opM pass when the subtract borrowed.
module sub_mod_seq
  import ecc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic [WIDTH-1:0] opM,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  state_t state, state_n;

  limbs_t a_q, b_q, m_q, res_q, res_nxt;
  logic [CNT_W-1:0] cnt;
  logic             cy;
  logic             last;
  logic             corr;
  logic [LIMB-1:0]  x, y, sum;
  logic             cout;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);
  assign last      = (cnt == CNT_W'(NLIMB - 1));
  assign corr      = (state == CORR);

  assign x = corr ? res_q[cnt] : a_q[cnt];
  assign y = corr ? m_q[cnt]   : b_q[cnt];

  limb_addsub u_alu (
    .sub  (!corr),
    .a    (x),
    .b    (y),
    .cin  (cy),
    .sum  (sum),
    .cout (cout)
  );

  always_comb begin
    res_nxt      = res_q;
    res_nxt[cnt] = sum;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (in_valid) state_n = SUB;
      SUB:  if (last) state_n = cout ? CORR : OUT;
      CORR: if (last) state_n = OUT;
      OUT:  if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      res_q    <= '0;
      cnt      <= '0;
      cy       <= 1'b0;
      out_data <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q <= opA;
            b_q <= opB;
            m_q <= opM;
            cnt <= '0;
            cy  <= 1'b0;
          end
        end
        SUB: begin
          res_q <= res_nxt;
          cy    <= cout;
          cnt   <= cnt + 1'b1;
          if (last) begin
            cnt <= '0;
            cy  <= 1'b0;
            if (!cout) out_data <= res_nxt;
          end
        end
        CORR: begin
          res_q <= res_nxt;
          cy    <= cout;
          cnt   <= cnt + 1'b1;
          // Final carry-out is dropped: the sum wraps mod 2^WIDTH
          if (last) begin
            cnt      <= '0;
            cy       <= 1'b0;
            out_data <= res_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_mod_seq.sv
// Scoreboard bench for sub_mod_seq: directed cases plus random traffic
// against a plain-arithmetic modular subtraction model.
module tb_sub_mod_seq;
  import ecc_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] opA, opB, opM;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  sub_mod_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opA       (opA),
    .opB       (opB),
    .opM       (opM),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] d;
    int lat;
    int acc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   rand_rdy = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name,
                       input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic [WIDTH-1:0] m);
    if (a >= b) return a - b;
    return a - b + m;
  endfunction

  function automatic logic [WIDTH-1:0] rnd256();
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic issue(input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] m);
    exp_t e;
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    opA = a;
    opB = b;
    opM = m;
    n = 0;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check(1'b0, "accept_timeout", '0, 1);
      in_valid = 1'b0;
      return;
    end
    e.d   = model(a, b, m);
    e.lat = (a >= b) ? NLIMB : 2 * NLIMB;
    e.acc = cyc + 1;
    @(posedge clk);
    q.push_back(e);
    #1;
    in_valid = 1'b0;
    opA = rnd256();
    opB = rnd256();
    opM = rnd256();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      check(1'b0, "drain_timeout", WIDTH'(q.size()), '0);
      q.delete();
    end
    @(negedge clk);
  endtask

  // Monitor: handshake-level checking against the queue head
  initial begin
    bit seen = 0;
    int first = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen = 0;
        continue;
      end
      check(in_ready == (q.size() == 0), "in_ready", WIDTH'(in_ready),
            WIDTH'(q.size() == 0));
      if (out_valid) begin
        if (q.size() == 0) begin
          check(1'b0, "spurious_out", out_data, '0);
        end else begin
          if (!seen) begin
            seen  = 1;
            first = cyc;
          end
          check(out_data == q[0].d, "out_data", out_data, q[0].d);
          if (out_ready) begin
            check(first - q[0].acc == q[0].lat, "latency",
                  WIDTH'(first - q[0].acc), WIDTH'(q[0].lat));
            void'(q.pop_front());
            seen = 0;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  logic [WIDTH-1:0] big, ra, rb, rm;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    opA = '0;
    opB = '0;
    opM = '0;
    #3;
    check(in_ready == 1'b1, "rst_in_ready", WIDTH'(in_ready), 1);
    check(out_valid == 1'b0, "rst_out_valid", WIDTH'(out_valid), 0);
    check(out_data == '0, "rst_out_data", out_data, '0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    issue(10, 3, 13);
    issue(3, 10, 13);
    big = {4{64'h1234_5678_9ABC_DEF0}};
    issue(big, big, P256K1);
    issue(0, 1, P256K1);
    wait_idle();

    // Backpressure with new operands pending
    out_ready = 1'b0;
    issue(10, 3, 13);
    fork
      issue(5, 9, 13);
      begin
        int n = 0;
        while (!out_valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        check(out_valid == 1'b1, "bp_valid_timeout", WIDTH'(out_valid), 1);
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_idle();

    // Reset during the correction pass
    issue(3, 10, 13);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    q.delete();
    #1;
    check(out_valid == 1'b0, "midrst_out_valid", WIDTH'(out_valid), 0);
    check(out_data == '0, "midrst_out_data", out_data, '0);
    check(in_ready == 1'b1, "midrst_in_ready", WIDTH'(in_ready), 1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    issue(10, 3, 13);
    wait_idle();

    // Random traffic with random output backpressure
    rand_rdy = 1;
    for (int i = 0; i < 40; i++) begin
      rm = rnd256() >> $urandom_range(0, 250);
      if (rm == '0) rm = 1;
      ra = rnd256() % rm;
      rb = rnd256() % rm;
      if (i % 7 == 0) rb = ra;
      issue(ra, rb, rm);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    @(posedge clk);
    #1;
    rand_rdy = 0;
    out_ready = 1'b1;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
